// File: rtl/arm_ctrl_pkg.sv
// Shared types, constants and the next-PC selection function for the ARM
// fetch controller.
package arm_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;

  // Widest PC the selection function handles. Narrower PCs are zero-extended
  // on entry and truncated on exit, which keeps the arithmetic modulo 2^WIDTH.
  localparam int MAX_WIDTH = 64;

  localparam int PC_INC        = 4;
  localparam int PC_R15_OFFSET = 8;

  // Redirect priority: ALU write to R15, then branch, then sequential.
  // Redirect targets are forced to word alignment.
  function automatic logic [MAX_WIDTH-1:0] next_pc_sel(
    input logic                 pc_write,
    input logic                 branch_taken,
    input logic [MAX_WIDTH-1:0] alu_result,
    input logic [MAX_WIDTH-1:0] branch_target,
    input logic [MAX_WIDTH-1:0] pc
  );
    logic [MAX_WIDTH-1:0] sel;
    if (pc_write) begin
      sel = alu_result & ~MAX_WIDTH'(3);
    end else if (branch_taken) begin
      sel = branch_target & ~MAX_WIDTH'(3);
    end else begin
      sel = pc + MAX_WIDTH'(PC_INC);
    end
    return sel;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: priority redirect select, word alignment
// and sequential increment, plus the R15 read value (pc + 8).
module pc_next_mux
  import arm_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             pc_write,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [WIDTH-1:0] pc,
  output logic             redirect,
  output logic [WIDTH-1:0] next_pc,
  output logic [WIDTH-1:0] pc_plus8
);

  logic [MAX_WIDTH-1:0] sel_wide;
  // Upper bits of the wide result are only meaningful when WIDTH == MAX_WIDTH.
  logic                 unused_sel;

  // Select in the wide domain, then truncate back to WIDTH (modulo wrap).
  always_comb begin
    sel_wide = next_pc_sel(pc_write, branch_taken,
                           MAX_WIDTH'(alu_result),
                           MAX_WIDTH'(branch_target),
                           MAX_WIDTH'(pc));
  end

  assign next_pc    = sel_wide[WIDTH-1:0];
  assign unused_sel = ^sel_wide;
  assign redirect   = pc_write | branch_taken;
  assign pc_plus8   = pc + WIDTH'(PC_R15_OFFSET);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction-fetch sequencer. Issues one fetch at
// a time over a req/ready handshake, presents the fetched PC to decode, and
// redirects on branch or R15 writes without ever withdrawing a request.
module pc_fetch_sequencer
  import arm_ctrl_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [WIDTH-1:0]     branch_target,
  input  logic                 pc_write,
  input  logic [WIDTH-1:0]     alu_result,
  output logic                 imem_req,
  output logic [WIDTH-1:0]     imem_addr,
  input  logic                 imem_ready,
  output logic                 instr_valid,
  output logic [WIDTH-1:0]     pc,
  output logic [WIDTH-1:0]     pc_plus8,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  fetch_state_t         state_reg, state_next;
  logic [WIDTH-1:0]     pc_reg, pc_next;
  logic [WIDTH-1:0]     pend_addr_reg, pend_addr_next;
  logic                 redirect_pend_reg, redirect_pend_next;
  logic [CNT_WIDTH-1:0] fetch_count_reg, fetch_count_next;

  logic                 redirect;
  logic [WIDTH-1:0]     mux_next_pc;

  pc_next_mux #(
    .WIDTH(WIDTH)
  ) u_pc_next_mux (
    .pc_write      (pc_write),
    .branch_taken  (branch_taken),
    .alu_result    (alu_result),
    .branch_target (branch_target),
    .pc            (pc_reg),
    .redirect      (redirect),
    .next_pc       (mux_next_pc),
    .pc_plus8      (pc_plus8)
  );

  // State, PC, pending-redirect and retired-fetch counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= BOOT;
      pc_reg            <= RESET_VECTOR;
      pend_addr_reg     <= '0;
      redirect_pend_reg <= 1'b0;
      fetch_count_reg   <= '0;
    end else begin
      state_reg         <= state_next;
      pc_reg            <= pc_next;
      pend_addr_reg     <= pend_addr_next;
      redirect_pend_reg <= redirect_pend_next;
      fetch_count_reg   <= fetch_count_next;
    end
  end

  // Next-state, PC update and handshake outputs.
  always_comb begin
    state_next         = state_reg;
    pc_next            = pc_reg;
    pend_addr_next     = pend_addr_reg;
    redirect_pend_next = redirect_pend_reg;
    fetch_count_next   = fetch_count_reg;
    imem_req           = 1'b0;
    instr_valid        = 1'b0;

    case (state_reg)
      BOOT: begin
        state_next = FETCH;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if (redirect) begin
            // Response belongs to the old stream: drop it and refetch.
            pc_next            = mux_next_pc;
            redirect_pend_next = 1'b0;
          end else if (redirect_pend_reg) begin
            pc_next            = pend_addr_reg;
            redirect_pend_next = 1'b0;
          end else begin
            state_next = ISSUE;
          end
        end else if (redirect) begin
          // Request stays in flight; remember the youngest redirect.
          pend_addr_next     = mux_next_pc;
          redirect_pend_next = 1'b1;
        end
      end

      ISSUE: begin
        instr_valid = 1'b1;
        if (!stall) begin
          fetch_count_next = fetch_count_reg + CNT_WIDTH'(1);
        end
        if (redirect || !stall) begin
          pc_next    = mux_next_pc;
          state_next = FETCH;
        end
      end

      default: begin
        state_next = BOOT;
      end
    endcase
  end

  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer. Expected accepted PCs are queued
// as stimulus is driven and popped whenever decode accepts an instruction.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, pc_write, imem_ready;
  logic [31:0] branch_target, alu_result;

  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, pc, pc_plus8;
  logic [15:0] fetch_count;

  logic        b_imem_req, b_instr_valid;
  logic [31:0] b_imem_addr, b_pc, b_pc_plus8;
  logic [15:0] b_fetch_count;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  pc_fetch_sequencer #(.WIDTH(32), .RESET_VECTOR(32'h0000_0000), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc_write(pc_write), .alu_result(alu_result),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .instr_valid(instr_valid), .pc(pc), .pc_plus8(pc_plus8), .fetch_count(fetch_count)
  );

  pc_fetch_sequencer #(.WIDTH(32), .RESET_VECTOR(32'hFFFF_FFFC), .CNT_WIDTH(16)) dut_wrap (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc_write(pc_write), .alu_result(alu_result),
    .imem_req(b_imem_req), .imem_addr(b_imem_addr), .imem_ready(imem_ready),
    .instr_valid(b_instr_valid), .pc(b_pc), .pc_plus8(b_pc_plus8), .fetch_count(b_fetch_count)
  );

  // Scoreboard: every instruction accepted by decode must match the queue head.
  always @(negedge clk) begin
    if (instr_valid === 1'b1 && stall === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL accept_unexpected pc=%h required=no_accept", pc);
      end else begin
        exp_pc = exp_q.pop_front();
        if (pc !== exp_pc) begin
          failures++;
          $display("FAIL accept_pc actual=%h required=%h", pc, exp_pc);
        end else begin
          $display("accept pc=%h count_before=%0d", pc, fetch_count);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; pc_write = 1'b0;
    branch_target = '0; alu_result = '0; imem_ready = 1'b0;
    step(); step();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req actual=%b required=0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b required=0", instr_valid); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc actual=%h required=0", pc); end
    checks++; if (fetch_count !== 16'h0) begin failures++; $display("FAIL reset_count actual=%0d required=0", fetch_count); end
    checks++; if (pc_plus8 !== 32'h8) begin failures++; $display("FAIL reset_pc8 actual=%h required=8", pc_plus8); end
    checks++; if (b_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL reset_vec_pc actual=%h required=fffffffc", b_pc); end
    checks++; if (b_pc_plus8 !== 32'h4) begin failures++; $display("FAIL reset_vec_pc8 actual=%h required=4", b_pc_plus8); end
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    reset = 1'b0; imem_ready = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      failures++; $display("FAIL seq_first_req actual=req%b/addr%h/valid%b required=1/0/0", imem_req, imem_addr, instr_valid); end
    step();
    checks++; if (instr_valid !== 1'b1 || pc !== 32'h0 || imem_req !== 1'b0) begin
      failures++; $display("FAIL seq_issue0 actual=valid%b/pc%h/req%b required=1/0/0", instr_valid, pc, imem_req); end
    checks++; if (pc_plus8 !== 32'h8) begin failures++; $display("FAIL seq_pc8 actual=%h required=8", pc_plus8); end
    step(); step();
    checks++; if (instr_valid !== 1'b1 || pc !== 32'h4) begin
      failures++; $display("FAIL seq_issue4 actual=valid%b/pc%h required=1/4", instr_valid, pc); end
    step();
    checks++; if (fetch_count !== 16'd2 || pc !== 32'h8 || imem_req !== 1'b1) begin
      failures++; $display("FAIL seq_fetch8 actual=cnt%0d/pc%h/req%b required=2/8/1", fetch_count, pc, imem_req); end
    $display("test_sequential done");
  endtask

  task automatic test_imem_wait();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin
        failures++; $display("FAIL wait_hold%0d actual=req%b/addr%h/valid%b required=1/8/0", i, imem_req, imem_addr, instr_valid); end
    end
    imem_ready = 1'b1;
    step();
    checks++; if (instr_valid !== 1'b1 || pc !== 32'h8) begin
      failures++; $display("FAIL wait_issue actual=valid%b/pc%h required=1/8", instr_valid, pc); end
    step();
    checks++; if (fetch_count !== 16'd3 || pc !== 32'hC || pc_plus8 !== 32'h14) begin
      failures++; $display("FAIL wait_count3 actual=cnt%0d/pc%h/pc8%h required=3/c/14", fetch_count, pc, pc_plus8); end
    $display("test_imem_wait done");
  endtask

  task automatic test_stall_branch();
    exp_q.push_back(32'hC);
    step(); step();
    checks++; if (pc !== 32'h10 || fetch_count !== 16'd4) begin
      failures++; $display("FAIL stall_setup actual=pc%h/cnt%0d required=10/4", pc, fetch_count); end
    stall = 1'b1;
    step(); step();
    checks++; if (instr_valid !== 1'b1 || pc !== 32'h10 || fetch_count !== 16'd4) begin
      failures++; $display("FAIL stall_hold actual=valid%b/pc%h/cnt%0d required=1/10/4", instr_valid, pc, fetch_count); end
    branch_taken = 1'b1; branch_target = 32'h103;
    step();
    checks++; if (pc !== 32'h100 || imem_req !== 1'b1 || instr_valid !== 1'b0 || fetch_count !== 16'd4) begin
      failures++; $display("FAIL stall_branch actual=pc%h/req%b/valid%b/cnt%0d required=100/1/0/4", pc, imem_req, instr_valid, fetch_count); end
    branch_taken = 1'b0; stall = 1'b0; imem_ready = 1'b0;
    $display("test_stall_branch done");
  endtask

  task automatic test_fetch_redirect();
    step();
    branch_taken = 1'b1; branch_target = 32'h40;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
      failures++; $display("FAIL pend_hold actual=req%b/addr%h/valid%b required=1/100/0", imem_req, imem_addr, instr_valid); end
    branch_taken = 1'b0;
    step();
    imem_ready = 1'b1;
    step();
    checks++; if (imem_addr !== 32'h40 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      failures++; $display("FAIL pend_refetch actual=addr%h/req%b/valid%b required=40/1/0", imem_addr, imem_req, instr_valid); end
    exp_q.push_back(32'h40);
    $display("test_fetch_redirect done");
  endtask

  task automatic test_priority();
    step();
    pc_write = 1'b1; alu_result = 32'h200; branch_taken = 1'b1; branch_target = 32'h300;
    step();
    checks++; if (pc !== 32'h200 || imem_req !== 1'b1 || fetch_count !== 16'd5) begin
      failures++; $display("FAIL priority actual=pc%h/req%b/cnt%0d required=200/1/5", pc, imem_req, fetch_count); end
    pc_write = 1'b0; branch_taken = 1'b0;
    $display("test_priority done");
  endtask

  task automatic test_back_to_back();
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h50;
    step();
    branch_taken = 1'b0; pc_write = 1'b1; alu_result = 32'h61;
    step();
    checks++; if (imem_addr !== 32'h200 || imem_req !== 1'b1) begin
      failures++; $display("FAIL b2b_hold actual=addr%h/req%b required=200/1", imem_addr, imem_req); end
    pc_write = 1'b0; imem_ready = 1'b1;
    step();
    checks++; if (pc !== 32'h60 || instr_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_youngest actual=pc%h/valid%b required=60/0", pc, instr_valid); end
    exp_q.push_back(32'h60);
    step(); step();
    checks++; if (pc !== 32'h64 || fetch_count !== 16'd6 || imem_req !== 1'b1) begin
      failures++; $display("FAIL b2b_after actual=pc%h/cnt%0d/req%b required=64/6/1", pc, fetch_count, imem_req); end
    $display("test_back_to_back done");
  endtask

  task automatic test_wrap_reset();
    reset = 1'b1;
    step();
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 || fetch_count !== 16'd0) begin
      failures++; $display("FAIL midfetch_reset actual=req%b/valid%b/pc%h/cnt%0d required=0/0/0/0", imem_req, instr_valid, pc, fetch_count); end
    checks++; if (b_pc !== 32'hFFFF_FFFC || b_imem_req !== 1'b0) begin
      failures++; $display("FAIL wrap_reset actual=pc%h/req%b required=fffffffc/0", b_pc, b_imem_req); end
    reset = 1'b0;
    exp_q.push_back(32'h0);
    step();
    checks++; if (b_imem_req !== 1'b1 || b_imem_addr !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_first actual=req%b/addr%h required=1/fffffffc", b_imem_req, b_imem_addr); end
    step();
    checks++; if (b_instr_valid !== 1'b1 || b_pc !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_issue actual=valid%b/pc%h required=1/fffffffc", b_instr_valid, b_pc); end
    step();
    checks++; if (b_imem_req !== 1'b1 || b_imem_addr !== 32'h0 || b_pc_plus8 !== 32'h8) begin
      failures++; $display("FAIL wrap_second actual=req%b/addr%h/pc8%h required=1/0/8", b_imem_req, b_imem_addr, b_pc_plus8); end
    $display("test_wrap_reset done");
  endtask

  task automatic test_drain();
    step();
    checks++; if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_imem_wait();
    test_stall_branch();
    test_fetch_redirect();
    test_priority();
    test_back_to_back();
    test_wrap_reset();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
